// File: rtl/reg_share_arbiter_pkg.sv
// Shared constants and helpers for the register-sharing arbiter.
package reg_share_arbiter_pkg;

  // Arbiter FSM encodings; kept as plain constants so older tools can use them.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  // Default configuration.
  localparam int DEF_NREQ     = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Ceiling log2, never less than 1 so that derived vectors are always legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/reg_bank_ffd.sv
// Load-enabled W-bit register bank built from individual D flip-flop cells.
// Each bit recirculates its own output when the load enable is low.

// Single D flip-flop cell with asynchronous active-high clear.
module ffd_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic bit_q;

  // Storage bit: clears immediately on rst, otherwise captures d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= d;
    end
  end

  assign q = bit_q;

endmodule

module reg_bank_ffd
  import reg_share_arbiter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] bit_d;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    // Enable mux: load new data or hold the current value.
    assign bit_d[gi] = en ? d[gi] : q[gi];

    ffd_cell u_ffd (
      .clk (clk),
      .rst (rst),
      .d   (bit_d[gi]),
      .q   (q[gi])
    );
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared W-bit register. Grants are registered one-hot, bounded to MAX_HOLD
// cycles, and separated by a RELEASE cycle plus an IDLE arbitration cycle.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clock,
  input  logic                     reset_ARB_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ*W-1:0]        data_in,
  output logic [NREQ-1:0]          gnt,
  output logic [clog2(NREQ)-1:0]   owner,
  output logic                     busy,
  output logic [W-1:0]             q,
  output logic                     timeout
);

  localparam int OW = clog2(NREQ);
  localparam int HW = clog2(MAX_HOLD + 1);

  logic [1:0]      state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [OW-1:0]   owner_q,   owner_d;
  logic [OW-1:0]   ptr_q,     ptr_d;
  logic [HW-1:0]   hold_q,    hold_d;
  logic            busy_q,    busy_d;
  logic            timeout_q, timeout_d;

  logic            pick_valid_s;
  logic [OW-1:0]   pick_s;
  logic [NREQ-1:0] pick_onehot_s;
  logic            owner_req_s;
  logic            owner_wr_s;
  logic [W-1:0]    owner_data_s;
  logic            bank_en_s;
  logic            bank_rst_s;

  // Round-robin search: first active request starting just after the pointer.
  always_comb begin
    pick_valid_s  = 1'b0;
    pick_s        = '0;
    pick_onehot_s = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_valid_s && req[i] && (((int'(ptr_q) + off) % NREQ) == i)) begin
          pick_valid_s     = 1'b1;
          pick_s           = OW'(i);
          pick_onehot_s[i] = 1'b1;
        end else begin
          pick_valid_s = pick_valid_s;
        end
      end
    end
  end

  // Select the current owner's request, write strobe and data lane.
  always_comb begin
    owner_req_s  = 1'b0;
    owner_wr_s   = 1'b0;
    owner_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(owner_q) == i) begin
        owner_req_s  = req[i];
        owner_wr_s   = wr[i];
        owner_data_s = data_in[i*W +: W];
      end else begin
        owner_req_s = owner_req_s;
      end
    end
  end

  // Only the owner may write, and only while the grant is active.
  always_comb begin
    bank_en_s  = (state_q == ST_GRANT) && owner_wr_s;
    bank_rst_s = ~reset_ARB_n;
  end

  // Arbiter next-state logic: grant, hold-limit, release.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d   = ST_GRANT;
          gnt_d     = pick_onehot_s;
          owner_d   = pick_s;
          ptr_d     = pick_s;
          hold_d    = '0;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b0;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          // Grant exhausted its budget; revoke it and flag the timeout.
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        hold_d    = '0;
      end
    endcase
  end

  // Arbiter state registers; ptr resets to the top index so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_ARB_n) begin
    if (!reset_ARB_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= OW'(NREQ - 1);
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  reg_bank_ffd #(
    .W (W)
  ) u_bank (
    .clk (clock),
    .rst (bank_rst_s),
    .en  (bank_en_s),
    .d   (owner_data_s),
    .q   (q)
  );

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with an expected-result queue.
module tb_reg_share_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] q;
    logic       timeout;
  } exp_t;

  logic        clock;
  logic        reset_ARB_n;
  logic [3:0]  req;
  logic [3:0]  wr;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic        timeout;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  reg_share_arbiter #(
    .NREQ     (4),
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clock       (clock),
    .reset_ARB_n (reset_ARB_n),
    .req         (req),
    .wr          (wr),
    .data_in     (data_in),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .q           (q),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o,
                              input logic b, input logic [7:0] qv, input logic t);
    exp_t e;
    e.gnt = g; e.owner = o; e.busy = b; e.q = qv; e.timeout = t;
    return e;
  endfunction

  function automatic logic [31:0] pack4(input logic [7:0] d3, input logic [7:0] d2,
                                        input logic [7:0] d1, input logic [7:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
    check({tag, ".owner"},   32'(owner),   32'(e.owner));
    check({tag, ".busy"},    32'(busy),    32'(e.busy));
    check({tag, ".q"},       32'(q),       32'(e.q));
    check({tag, ".timeout"}, 32'(timeout), 32'(e.timeout));
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] w,
                      input logic [31:0] d, input exp_t e);
    exp_t exp_e;
    @(negedge clock);
    req = r; wr = w; data_in = d;
    sb.push_back(e);
    @(posedge clock);
    #1;
    exp_e = sb.pop_front();
    check_all(tag, exp_e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ARB_n = 1'b0;
    req = 4'b0000; wr = 4'b0000; data_in = 32'h0;
    @(negedge clock);
    reset_ARB_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  oh;
    logic [1:0]  o;
    logic [7:0]  dv;
    logic [7:0]  dlast;
    logic [7:0]  prevq;
    logic [31:0] d;
    logic [31:0] dl;

    vectors = 0; miscompares = 0;
    clock = 1'b0; reset_ARB_n = 1'b0;
    req = 4'b0000; wr = 4'b0000; data_in = 32'h0;

    // Reset state
    #12;
    check_all("reset", mk(4'b0000, 2'd0, 1'b0, 8'h00, 1'b0));
    @(negedge clock);
    reset_ARB_n = 1'b1;

    // Single write then release
    step("sw_arb",  4'b0001, 4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'hA5), mk(4'b0001, 2'd0, 1'b1, 8'h00, 1'b0));
    step("sw_wr",   4'b0001, 4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'hA5), mk(4'b0001, 2'd0, 1'b1, 8'hA5, 1'b0));
    step("sw_rel",  4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd0, 1'b0, 8'hA5, 1'b0));
    step("sw_idle", 4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd0, 1'b0, 8'hA5, 1'b0));
    step("sw_hold", 4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd0, 1'b0, 8'hA5, 1'b0));

    // Non-owner writes are ignored
    step("no_arb",  4'b0001, 4'b0000, 32'h0, mk(4'b0001, 2'd0, 1'b1, 8'hA5, 1'b0));
    step("no_foe",  4'b0001, 4'b1010, pack4(8'hFF, 8'h00, 8'hFF, 8'h00), mk(4'b0001, 2'd0, 1'b1, 8'hA5, 1'b0));
    step("no_own",  4'b0001, 4'b0001, pack4(8'hFF, 8'h00, 8'hFF, 8'h12), mk(4'b0001, 2'd0, 1'b1, 8'h12, 1'b0));
    step("no_rel",  4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd0, 1'b0, 8'h12, 1'b0));
    step("no_idle", 4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd0, 1'b0, 8'h12, 1'b0));
    step("no_idwr", 4'b0000, 4'b1111, 32'hEEEEEEEE, mk(4'b0000, 2'd0, 1'b0, 8'h12, 1'b0));

    // Immediate drop: one GRANT cycle, write honoured on the releasing edge
    step("id_arb",  4'b1000, 4'b0000, 32'h0, mk(4'b1000, 2'd3, 1'b1, 8'h12, 1'b0));
    step("id_wr",   4'b0000, 4'b1000, pack4(8'h77, 8'h00, 8'h00, 8'h00), mk(4'b0000, 2'd3, 1'b0, 8'h77, 1'b0));
    step("id_idle", 4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd3, 1'b0, 8'h77, 1'b0));

    // Reset in the middle of a grant to requester 2
    step("mr_arb",  4'b0100, 4'b0000, 32'h0, mk(4'b0100, 2'd2, 1'b1, 8'h77, 1'b0));
    step("mr_wr",   4'b0100, 4'b0100, pack4(8'h00, 8'h3C, 8'h00, 8'h00), mk(4'b0100, 2'd2, 1'b1, 8'h3C, 1'b0));
    #2;
    reset_ARB_n = 1'b0;
    #1;
    check_all("mr_async", mk(4'b0000, 2'd0, 1'b0, 8'h00, 1'b0));
    @(negedge clock);
    req = 4'b0000; wr = 4'b0000;
    @(negedge clock);
    reset_ARB_n = 1'b1;
    step("mr_again", 4'b0100, 4'b0000, 32'h0, mk(4'b0100, 2'd2, 1'b1, 8'h00, 1'b0));
    step("mr_rel",   4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd2, 1'b0, 8'h00, 1'b0));
    step("mr_idle",  4'b0000, 4'b0000, 32'h0, mk(4'b0000, 2'd2, 1'b0, 8'h00, 1'b0));

    // Round robin with all requesters active; the released requester re-requests at once
    do_reset();
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      o  = 2'(k);
      step($sformatf("rr%0d_arb", k), 4'b1111, 4'b0000, 32'h0, mk(oh, o, 1'b1, 8'h00, 1'b0));
      step($sformatf("rr%0d_g1", k),  4'b1111, 4'b0000, 32'h0, mk(oh, o, 1'b1, 8'h00, 1'b0));
      step($sformatf("rr%0d_g2", k),  4'b1111 & ~oh, 4'b0000, 32'h0, mk(4'b0000, o, 1'b0, 8'h00, 1'b0));
      step($sformatf("rr%0d_rel", k), 4'b1111 & ~oh, 4'b0000, 32'h0, mk(4'b0000, o, 1'b0, 8'h00, 1'b0));
    end

    // Timeout: two requesters hold req forever and alternate every MAX_HOLD cycles
    do_reset();
    prevq = 8'h00;
    d = pack4(8'h00, 8'h22, 8'h11, 8'h00);
    for (int g = 0; g < 3; g++) begin
      o     = (g == 1) ? 2'd2 : 2'd1;
      oh    = 4'b0001 << o;
      dv    = (g == 1) ? 8'h22 : 8'h11;
      dlast = 8'h30 + 8'(o);
      dl    = (g == 1) ? pack4(8'h00, dlast, 8'h11, 8'h00) : pack4(8'h00, 8'h22, dlast, 8'h00);
      step($sformatf("to%0d_arb", g), 4'b0110, 4'b0110, d, mk(oh, o, 1'b1, prevq, 1'b0));
      for (int c = 0; c < 3; c++) begin
        step($sformatf("to%0d_h%0d", g, c), 4'b0110, 4'b0110, d, mk(oh, o, 1'b1, dv, 1'b0));
      end
      step($sformatf("to%0d_rev", g),  4'b0110, 4'b0110, dl, mk(4'b0000, o, 1'b0, dlast, 1'b1));
      step($sformatf("to%0d_idle", g), 4'b0110, 4'b0110, d,  mk(4'b0000, o, 1'b0, dlast, 1'b0));
      prevq = dlast;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
